mux4_vector_checker: RTL and testbench

- Hardware test-vector player and checker that drives the 4:1 multiplexer stage (d0..d3, s) and checks its output y.
- Holds up to VEC_DEPTH vectors in an internal register-file memory loaded through a write port.
- Each vector is packed {d0, d1, d2, d3, s, y_exp}; with WIDTH=4 this is 22 bits.
- Applies the vectors one by one, compares y against y_exp, and reports the error count, the first failing index and a final pass/fail verdict, so the mux can be checked on-board without a simulator.

---
 rtl/mux4_vector_checker.sv | 193 +++++++++++++++++++
 tb/tb_mux4_vector_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4_vector_checker.sv
// Test-vector player/checker for a 4:1 mux stage.
// Vectors {d0,d1,d2,d3,s,y_exp} are written into a small register-file memory,
// then replayed two cycles each: APPLY drives d*/s, CHECK compares the returned y
// against the expected value once it has had a full cycle to settle.
module mux4_vector_checker #(
    parameter int WIDTH     = 4,
    parameter int VEC_DEPTH = 16,
    parameter int ADDR_W    = 4,
    localparam int VEC_W    = 4*WIDTH + 2 + WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vec_we,
    input  logic [ADDR_W-1:0] vec_waddr,
    input  logic [VEC_W-1:0]  vec_wdata,
    input  logic [ADDR_W:0]   num_vec,
    input  logic              start,
    output logic [WIDTH-1:0]  d0,
    output logic [WIDTH-1:0]  d1,
    output logic [WIDTH-1:0]  d2,
    output logic [WIDTH-1:0]  d3,
    output logic [1:0]        s,
    input  logic [WIDTH-1:0]  y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err_pulse,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = VEC_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   ONE_W   = 1;
    localparam logic [ADDR_W-1:0] ONE_A   = 1;

    // Vector memory; contents survive reset so a run can be repeated after abort.
    logic [VEC_W-1:0] mem [VEC_DEPTH];

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   idx_reg, idx_next;
    logic [ADDR_W:0]     n_reg, n_next;
    logic [WIDTH-1:0]    y_exp_reg, y_exp_next;
    logic [WIDTH-1:0]    d_reg [4];
    logic [WIDTH-1:0]    d_next [4];
    logic [1:0]          s_reg, s_next;
    logic [ADDR_W:0]     err_count_reg, err_count_next;
    logic [ADDR_W-1:0]   first_err_idx_reg, first_err_idx_next;
    logic                err_pulse_reg, err_pulse_next;

    logic [VEC_W-1:0]    rd_word;
    logic [WIDTH-1:0]    rd_d [4];
    logic [1:0]          rd_s;
    logic [WIDTH-1:0]    rd_y_exp;
    logic                idle_like;
    logic                wr_ok;
    logic                mismatch;
    logic                last_vec;
    logic [ADDR_W:0]     n_clamped;

    assign idle_like = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign wr_ok     = vec_we && idle_like && ({1'b0, vec_waddr} < DEPTH_C);

    // Memory write port: only accepted while no run is in progress.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[vec_waddr] <= vec_wdata;
        end
    end

    // Unpack the addressed vector; d0 occupies the most significant field.
    assign rd_word = mem[idx_reg];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign rd_d[gi] = rd_word[VEC_W-1-gi*WIDTH -: WIDTH];
        end
    endgenerate
    assign rd_s     = rd_word[WIDTH+1:WIDTH];
    assign rd_y_exp = rd_word[WIDTH-1:0];

    // Case-equality compare so an unknown y is treated as a failure in simulation.
    assign mismatch  = (y !== y_exp_reg);
    assign last_vec  = (({1'b0, idx_reg} + ONE_W) == n_reg);
    assign n_clamped = (num_vec > DEPTH_C) ? DEPTH_C : num_vec;

    // State and datapath registers, cleared by synchronous reset (memory excluded).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            idx_reg           <= '0;
            n_reg             <= '0;
            y_exp_reg         <= '0;
            s_reg             <= '0;
            err_count_reg     <= '0;
            first_err_idx_reg <= '0;
            err_pulse_reg     <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                d_reg[k] <= '0;
            end
        end else begin
            state_reg         <= state_next;
            idx_reg           <= idx_next;
            n_reg             <= n_next;
            y_exp_reg         <= y_exp_next;
            s_reg             <= s_next;
            err_count_reg     <= err_count_next;
            first_err_idx_reg <= first_err_idx_next;
            err_pulse_reg     <= err_pulse_next;
            for (int k = 0; k < 4; k++) begin
                d_reg[k] <= d_next[k];
            end
        end
    end

    // Next-state and datapath update for the IDLE/APPLY/CHECK/DONE sequencer.
    always_comb begin
        state_next         = state_reg;
        idx_next           = idx_reg;
        n_next             = n_reg;
        y_exp_next         = y_exp_reg;
        s_next             = s_reg;
        err_count_next     = err_count_reg;
        first_err_idx_next = first_err_idx_reg;
        err_pulse_next     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d_next[k] = d_reg[k];
        end

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_count_next     = '0;
                    first_err_idx_next = '0;
                    if (num_vec == '0) begin
                        // Empty run completes immediately and trivially passes.
                        state_next = ST_DONE;
                    end else begin
                        n_next     = n_clamped;
                        idx_next   = '0;
                        state_next = ST_APPLY;
                    end
                end
            end
            ST_APPLY: begin
                for (int k = 0; k < 4; k++) begin
                    d_next[k] = rd_d[k];
                end
                s_next     = rd_s;
                y_exp_next = rd_y_exp;
                state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_pulse_next = 1'b1;
                    if (err_count_reg != '1) begin
                        err_count_next = err_count_reg + ONE_W;
                    end
                    if (err_count_reg == '0) begin
                        first_err_idx_next = idx_reg;
                    end
                end
                if (last_vec) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx_reg + ONE_A;
                    state_next = ST_APPLY;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign d0            = d_reg[0];
    assign d1            = d_reg[1];
    assign d2            = d_reg[2];
    assign d3            = d_reg[3];
    assign s             = s_reg;
    assign busy          = (state_reg == ST_APPLY) || (state_reg == ST_CHECK);
    assign done          = (state_reg == ST_DONE);
    assign pass          = done && (err_count_reg == '0);
    assign err_pulse     = err_pulse_reg;
    assign err_count     = err_count_reg;
    assign first_err_idx = first_err_idx_reg;

endmodule

// File: tb/tb_mux4_vector_checker.sv
// Bench for mux4_vector_checker: a behavioural mux4 (with optional stuck-select
// fault) closes the loop; a table of runs plus hand-written reset/abort sequences.
module tb_mux4_vector_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        vec_we;
    logic [3:0]  vec_waddr;
    logic [21:0] vec_wdata;
    logic [4:0]  num_vec;
    logic        start;
    logic [3:0]  d0, d1, d2, d3;
    logic [1:0]  s;
    logic [3:0]  y;
    logic        busy, done, pass, err_pulse;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic        fault;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux4_vector_checker #(.WIDTH(4), .VEC_DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .vec_we(vec_we), .vec_waddr(vec_waddr),
        .vec_wdata(vec_wdata), .num_vec(num_vec), .start(start),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .s(s), .y(y),
        .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    // Mux under test; fault forces the select to 0.
    always_comb begin
        y = d0;
        if (!fault) begin
            case (s)
                2'd0: y = d0;
                2'd1: y = d1;
                2'd2: y = d2;
                default: y = d3;
            endcase
        end
    end

    typedef struct {
        int n;        // num_vec applied
        bit reload;   // rewrite the 16 good vectors first
        bit bad5;     // entry 5 gets y_exp=F
        bit fault;    // stuck-select mux
        int we_cyc;   // cycle (0=start cycle) of a write of bad_vec, -1 none
        int we_addr;
        int exp_err;
        int exp_first;
        int exp_pass;
        int exp_busy;
        int exp_pulses;
        int exp_lat;
        int exp_s;    // s held in DONE, -1 = do not check
    } row_t;

    row_t rows [11];

    localparam logic [21:0] BAD_VEC = {4'h1, 4'h2, 4'h4, 4'h8, 2'd0, 4'hF};

    function automatic logic [21:0] good_vec(input int i);
        logic [1:0] sv;
        logic [3:0] ye;
        sv = i[1:0];
        ye = 4'h1 << sv;
        return {4'h1, 4'h2, 4'h4, 4'h8, sv, ye};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input bit bad5);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            vec_we    = 1'b1;
            vec_waddr = i[3:0];
            vec_wdata = (bad5 && i == 5) ? {4'h1, 4'h2, 4'h4, 4'h8, 2'd1, 4'hF} : good_vec(i);
        end
        @(negedge clk);
        vec_we = 1'b0;
    endtask

    // Pulse start and follow the run until done, counting busy and err_pulse cycles.
    task automatic run(input int n, input int we_cyc, input int we_addr,
                       output int busy_cnt, output int pulse_cnt, output int lat);
        busy_cnt  = 0;
        pulse_cnt = 0;
        lat       = -1;
        @(negedge clk);
        start   = 1'b1;
        num_vec = n[4:0];
        if (we_cyc == 0) begin
            vec_we    = 1'b1;
            vec_waddr = we_addr[3:0];
            vec_wdata = BAD_VEC;
        end
        @(negedge clk);
        start  = 1'b0;
        vec_we = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (busy) busy_cnt++;
            if (err_pulse) pulse_cnt++;
            if (done) begin
                lat = cyc;
                break;
            end
            if (cyc == we_cyc) begin
                vec_we    = 1'b1;
                vec_waddr = we_addr[3:0];
                vec_wdata = BAD_VEC;
            end else begin
                vec_we = 1'b0;
            end
            @(negedge clk);
        end
        vec_we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " d0"}, int'(d0), 0);
        check({tag, " d1"}, int'(d1), 0);
        check({tag, " d2"}, int'(d2), 0);
        check({tag, " d3"}, int'(d3), 0);
        check({tag, " s"}, int'(s), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " pass"}, int'(pass), 0);
        check({tag, " err_pulse"}, int'(err_pulse), 0);
        check({tag, " err_count"}, int'(err_count), 0);
        check({tag, " first_err_idx"}, int'(first_err_idx), 0);
    endtask

    initial begin
        int b, p, l, done_seen;

        //         n  rl b5 f  wec wa err fst ps busy pul lat s
        rows[0]  = '{16, 1, 0, 0, -1, 0,  0, 0, 1, 32,  0, 33, 3};
        rows[1]  = '{16, 1, 1, 0, -1, 0,  1, 5, 0, 32,  1, 33, 3};
        rows[2]  = '{16, 1, 0, 1, -1, 0, 12, 1, 0, 32, 12, 33, 3};
        rows[3]  = '{ 0, 0, 0, 0, -1, 0,  0, 0, 1,  0,  0,  1, -1};
        rows[4]  = '{20, 0, 0, 0, -1, 0,  0, 0, 1, 32,  0, 33, 3};
        rows[5]  = '{ 3, 0, 0, 1, -1, 0,  2, 1, 0,  6,  2,  7, 2};
        rows[6]  = '{16, 0, 0, 0,  5, 3,  0, 0, 1, 32,  0, 33, 3};
        rows[7]  = '{16, 0, 0, 0, -1, 0,  0, 0, 1, 32,  0, 33, 3};
        rows[8]  = '{ 1, 0, 0, 0,  0, 0,  1, 0, 0,  2,  1,  3, 0};
        rows[9]  = '{16, 0, 0, 0, -1, 0,  1, 0, 0, 32,  1, 33, 3};
        rows[10] = '{16, 1, 0, 0, -1, 0,  0, 0, 1, 32,  0, 33, 3};

        reset = 1'b1; vec_we = 1'b0; vec_waddr = '0; vec_wdata = '0;
        num_vec = '0; start = 1'b0; fault = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        for (int r = 0; r < 11; r++) begin
            if (rows[r].reload) load_mem(rows[r].bad5);
            fault = rows[r].fault;
            run(rows[r].n, rows[r].we_cyc, rows[r].we_addr, b, p, l);
            $display("row %0d: n=%0d err_count=%0d first=%0d pass=%0d busy=%0d pulses=%0d lat=%0d",
                     r, rows[r].n, err_count, first_err_idx, pass, b, p, l);
            check($sformatf("row%0d latency", r), l, rows[r].exp_lat);
            check($sformatf("row%0d err_count", r), int'(err_count), rows[r].exp_err);
            check($sformatf("row%0d first_err_idx", r), int'(first_err_idx), rows[r].exp_first);
            check($sformatf("row%0d pass", r), int'(pass), rows[r].exp_pass);
            check($sformatf("row%0d busy_cycles", r), b, rows[r].exp_busy);
            check($sformatf("row%0d err_pulses", r), p, rows[r].exp_pulses);
            if (rows[r].exp_s >= 0) begin
                check($sformatf("row%0d held_s", r), int'(s), rows[r].exp_s);
                check($sformatf("row%0d held_d2", r), int'(d2), 4);
            end
        end

        // Abort a faulty run with reset at cycle 7, then confirm no done appears.
        fault = 1'b1;
        @(negedge clk);
        start = 1'b1; num_vec = 5'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        $display("abort: cycle 7 err_count=%0d busy=%0d", err_count, busy);
        check("abort pre err_count", int'(err_count), 2);
        check("abort pre busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        reset = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        $display("abort: idle after reset, done/busy cycles=%0d", done_seen);
        check("abort stays idle", done_seen, 0);

        // Fresh run after abort uses the untouched memory.
        fault = 1'b0;
        run(16, -1, 0, b, p, l);
        $display("rerun after abort: err_count=%0d pass=%0d lat=%0d", err_count, pass, l);
        check("rerun latency", l, 33);
        check("rerun err_count", int'(err_count), 0);
        check("rerun pass", int'(pass), 1);
        check("rerun busy_cycles", b, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
